// File: rtl/arm_data_mem_responder_if.sv
// Signal bundle between the ARM core data port, the log-draining host and the
// data-memory responder. The responder uses the slave view.
interface arm_data_mem_responder_if #(
  parameter int BusWidth = 32
);
  logic [BusWidth-1:0] Address;
  logic [BusWidth-1:0] Write_Data;
  logic                Mem_Write;
  logic [BusWidth-1:0] Read_Data;
  logic                Bus_Error;
  logic [1:0]          Status;
  logic                Timed_Out;
  logic                Log_Valid;
  logic [BusWidth-1:0] Log_Addr;
  logic [BusWidth-1:0] Log_Data;
  logic                Log_Pop;
  logic                Log_Overflow;

  modport slave (
    input  Address, Write_Data, Mem_Write, Log_Pop,
    output Read_Data, Bus_Error, Status, Timed_Out,
           Log_Valid, Log_Addr, Log_Data, Log_Overflow
  );

  modport master (
    output Address, Write_Data, Mem_Write, Log_Pop,
    input  Read_Data, Bus_Error, Status, Timed_Out,
           Log_Valid, Log_Addr, Log_Data, Log_Overflow
  );
endinterface

// File: rtl/arm_data_mem_responder.sv
// Data-side RAM for the single-cycle ARM core, with a pass/fail store checker,
// watchdog and a store-log FIFO drained through a valid/pop handshake.
module arm_data_mem_responder #(
  parameter int BusWidth   = 32,
  parameter int DEPTH      = 64,
  parameter int PASS_ADDR  = 100,
  parameter int PASS_VALUE = 7,
  parameter int TIMEOUT    = 1000,
  parameter int LOG_DEPTH  = 8
) (
  input logic                     CLK,
  input logic                     RESET,
  arm_data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LOG_DEPTH);
  localparam int CW = LW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [BusWidth-1:0] MEM_BYTES = BusWidth'(4 * DEPTH);
  localparam logic [BusWidth-1:0] PASS_A    = BusWidth'(PASS_ADDR);
  localparam logic [BusWidth-1:0] PASS_D    = BusWidth'(PASS_VALUE);
  localparam logic [WW-1:0]       WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0]       LOG_FULL  = CW'(LOG_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  function automatic logic addr_ok(input logic [BusWidth-1:0] a);
    return (a[1:0] == 2'b00) && (a < MEM_BYTES);
  endfunction

  // RAM and address decode
  logic [BusWidth-1:0] r_mem [DEPTH];
  logic [AW-1:0]       w_idx;
  logic                w_addr_ok;
  logic                w_store_ok;
  logic                w_pass_store;
  logic [BusWidth-1:0] w_rd_data;

  // checker FSM and flags
  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_wd;
  logic [WW-1:0] w_wd_nxt;
  logic          w_timeout_set;
  logic          r_timed_out;
  logic          r_bus_err;
  logic          w_bus_err_set;

  // store log
  logic [BusWidth-1:0] r_log_addr_mem [LOG_DEPTH];
  logic [BusWidth-1:0] r_log_data_mem [LOG_DEPTH];
  logic [LW-1:0]       r_wr_ptr;
  logic [LW-1:0]       r_rd_ptr;
  logic [LW-1:0]       w_rd_ptr_nxt;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_after_pop;
  logic [CW-1:0]       w_count_nxt;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_ovf_set;
  logic                r_log_valid;
  logic [BusWidth-1:0] r_log_addr;
  logic [BusWidth-1:0] r_log_data;
  logic                w_head_valid_nxt;
  logic [BusWidth-1:0] w_head_addr_nxt;
  logic [BusWidth-1:0] w_head_data_nxt;
  logic                r_ovf;

  assign w_idx        = bus.Address[AW+1:2];
  assign w_addr_ok    = addr_ok(bus.Address);
  assign w_store_ok   = bus.Mem_Write && w_addr_ok;
  assign w_pass_store = bus.Mem_Write && (bus.Address == PASS_A);

  always_comb begin
    w_rd_data = '0;
    if (w_addr_ok) begin
      w_rd_data = r_mem[w_idx];
    end else begin
      w_rd_data = '0;
    end
  end

  // RAM keeps its contents across RESET; a store in the reset cycle still lands
  always_ff @(posedge CLK) begin
    if (w_store_ok) begin
      r_mem[w_idx] <= bus.Write_Data;
    end
  end

  assign w_bus_err_set = !w_addr_ok && (bus.Mem_Write || (r_state == ST_RUN));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bus_err <= 1'b0;
    end else if (w_bus_err_set) begin
      r_bus_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_wd        <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wd        <= w_wd_nxt;
      r_timed_out <= r_timed_out | w_timeout_set;
    end
  end

  // a PASS_ADDR store outranks watchdog expiry in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_wd_nxt      = r_wd;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_wd != WD_LAST) begin
          w_wd_nxt = r_wd + WW'(1);
        end else begin
          w_wd_nxt = r_wd;
        end
        if (w_pass_store) begin
          w_state_nxt = (bus.Write_Data == PASS_D) ? ST_PASS : ST_FAIL;
        end else if (r_wd == WD_LAST) begin
          w_state_nxt   = ST_FAIL;
          w_timeout_set = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PASS: begin
        w_state_nxt = ST_PASS;
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_full            = (r_count == LOG_FULL);
    w_pop             = bus.Log_Pop && r_log_valid;
    w_push            = w_store_ok && (!w_full || w_pop);
    w_ovf_set         = w_store_ok && w_full && !w_pop;
    w_rd_ptr_nxt      = w_pop ? (r_rd_ptr + LW'(1)) : r_rd_ptr;
    w_count_after_pop = w_pop ? (r_count - CW'(1)) : r_count;
    w_count_nxt       = w_push ? (w_count_after_pop + CW'(1)) : w_count_after_pop;
    w_head_valid_nxt  = (w_count_nxt != '0);
    // the entry being pushed becomes the head when nothing older remains
    if (!w_head_valid_nxt) begin
      w_head_addr_nxt = '0;
      w_head_data_nxt = '0;
    end else if (w_push && (w_count_after_pop == '0)) begin
      w_head_addr_nxt = bus.Address;
      w_head_data_nxt = bus.Write_Data;
    end else begin
      w_head_addr_nxt = r_log_addr_mem[w_rd_ptr_nxt];
      w_head_data_nxt = r_log_data_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !RESET) begin
      r_log_addr_mem[r_wr_ptr] <= bus.Address;
      r_log_data_mem[r_wr_ptr] <= bus.Write_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_log_valid <= 1'b0;
      r_log_addr  <= '0;
      r_log_data  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_ptr    <= w_push ? (r_wr_ptr + LW'(1)) : r_wr_ptr;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_log_valid <= w_head_valid_nxt;
      r_log_addr  <= w_head_addr_nxt;
      r_log_data  <= w_head_data_nxt;
      r_ovf       <= r_ovf | w_ovf_set;
    end
  end

  assign bus.Read_Data    = w_rd_data;
  assign bus.Bus_Error    = r_bus_err;
  assign bus.Status       = r_state;
  assign bus.Timed_Out    = r_timed_out;
  assign bus.Log_Valid    = r_log_valid;
  assign bus.Log_Addr     = r_log_addr;
  assign bus.Log_Data     = r_log_data;
  assign bus.Log_Overflow = r_ovf;
endmodule

// File: tb/tb_arm_data_mem_responder.sv
// Self-checking bench: directed test-plan sequences followed by random traffic,
// all compared against a behavioural model of memory, checker and store log.
module tb_arm_data_mem_responder;
  localparam int TMO = 20;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  arm_data_mem_responder_if #(.BusWidth(32)) bus_if ();

  arm_data_mem_responder #(
    .BusWidth(32), .DEPTH(64), .PASS_ADDR(100), .PASS_VALUE(7),
    .TIMEOUT(TMO), .LOG_DEPTH(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus_if)
  );

  // reference model state
  logic [31:0] m_mem [64];
  bit          m_known [64];
  int          m_state;
  int          m_run_edges;
  bit          m_to;
  bit          m_be;
  bit          m_ovf;
  logic [63:0] m_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input logic [31:0] a, input logic [31:0] d,
                       input bit we, input bit pop);
    bit         ok;
    bit         popped;
    logic [5:0] idx;
    RESET              = rst;
    bus_if.Address     = a;
    bus_if.Write_Data  = d;
    bus_if.Mem_Write   = we;
    bus_if.Log_Pop     = pop;
    #1;
    ok  = (a[1:0] == 2'b00) && (a < 32'd256);
    idx = a[7:2];
    if (!ok) check_eq("read_bad_addr", bus_if.Read_Data, 32'h0);
    else if (m_known[idx]) check_eq("read_data", bus_if.Read_Data, m_mem[idx]);
    @(posedge CLK);
    if (we && ok) begin
      m_mem[idx]   = d;
      m_known[idx] = 1'b1;
    end
    if (rst) begin
      m_state = 0; m_run_edges = 0; m_to = 0; m_be = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (!ok && (we || m_state == 1)) m_be = 1;
      popped = pop && (m_q.size() > 0);
      if (popped) void'(m_q.pop_front());
      if (we && ok) begin
        if (m_q.size() < 8) m_q.push_back({a, d});
        else m_ovf = 1;
      end
      if (m_state == 0) begin
        m_state = 1;
        m_run_edges = 0;
      end else if (m_state == 1) begin
        m_run_edges++;
        if (we && a == 32'd100) m_state = (d == 32'd7) ? 2 : 3;
        else if (m_run_edges == TMO) begin
          m_state = 3;
          m_to = 1;
        end
      end
    end
    #1;
    check_eq("status", {30'd0, bus_if.Status}, 32'(m_state));
    check_eq("timed_out", {31'd0, bus_if.Timed_Out}, {31'd0, m_to});
    check_eq("bus_error", {31'd0, bus_if.Bus_Error}, {31'd0, m_be});
    check_eq("log_overflow", {31'd0, bus_if.Log_Overflow}, {31'd0, m_ovf});
    check_eq("log_valid", {31'd0, bus_if.Log_Valid}, {31'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      check_eq("log_addr", bus_if.Log_Addr, m_q[0][63:32]);
      check_eq("log_data", bus_if.Log_Data, m_q[0][31:0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    bit          rwe;
    bit          rpop;
    bit          rrst;
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    m_state = 0; m_run_edges = 0; m_to = 0; m_be = 0; m_ovf = 0;
    RESET = 1'b1;
    bus_if.Address = 32'd0; bus_if.Write_Data = 32'd0;
    bus_if.Mem_Write = 1'b0; bus_if.Log_Pop = 1'b0;

    // reset held for cycles 0..2, then store/load at address 8
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd8, 32'hA5, 1'b1, 1'b0);
    cycle(1'b0, 32'd8, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd8, 32'd0, 1'b0, 1'b0);

    // pass, then a later store keeps PASS but updates RAM
    cycle(1'b0, 32'd100, 32'd7, 1'b1, 1'b1);
    cycle(1'b0, 32'd100, 32'd3, 1'b1, 1'b1);
    cycle(1'b0, 32'd100, 32'd0, 1'b0, 1'b1);
    check_eq("ram25_after_pass", bus_if.Read_Data, 32'd3);

    // fail by data, then fail by watchdog
    do_reset();
    cycle(1'b0, 32'd100, 32'd5, 1'b1, 1'b0);
    idle(2);
    do_reset();
    idle(TMO + 3);

    // misaligned and out-of-range stores
    do_reset();
    cycle(1'b0, 32'd4, 32'h44, 1'b1, 1'b0);
    cycle(1'b0, 32'd6, 32'h11, 1'b1, 1'b0);
    cycle(1'b0, 32'd256, 32'h22, 1'b1, 1'b0);
    cycle(1'b0, 32'd4, 32'd0, 1'b0, 1'b1);

    // nine stores into an eight-entry log, then drain
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b0, 32'(4 * i), 32'(32'h100 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // full log with simultaneous store and pop
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'(4 * i), 32'(32'h200 + i), 1'b1, 1'b0);
    cycle(1'b0, 32'd64, 32'h55, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // reset mid-run after three logged stores, one store during reset
    do_reset();
    cycle(1'b0, 32'd120, 32'hC0, 1'b1, 1'b0);
    cycle(1'b0, 32'd124, 32'hC4, 1'b1, 1'b0);
    cycle(1'b0, 32'd128, 32'hC8, 1'b1, 1'b0);
    cycle(1'b1, 32'd132, 32'hCC, 1'b1, 1'b0);
    cycle(1'b0, 32'd120, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd128, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd132, 32'd0, 1'b0, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = 32'd100;
        1:       ra = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        2:       ra = 32'($urandom_range(64, 255)) << 2;
        default: ra = 32'($urandom_range(0, 63)) << 2;
      endcase
      rd   = (ra == 32'd100 && $urandom_range(0, 1) == 0) ? 32'd7 : $urandom;
      rwe  = ($urandom_range(0, 2) != 0);
      rpop = ($urandom_range(0, 2) == 0);
      rrst = ($urandom_range(0, 59) == 0);
      cycle(rrst, ra, rd, rwe, rpop);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/arm_data_mem_responder.md
Name: arm_data_mem_responder

Overview:
Data-side responder for the single-cycle ARM core. Word-addressed RAM with combinational read and synchronous write, which the core's load/store path needs. Also contains a store-checker FSM with a watchdog and a store-log FIFO. The FSM turns the program's "write 7 to address 100" completion convention into pass/fail status. A host or bench drains the FIFO through a valid/pop handshake.

Parameters:
BusWidth, 32, data/address width
DEPTH, 64, RAM size in words; valid byte addresses are 0 .. 4*DEPTH-4
PASS_ADDR, 100, byte address watched by the checker
PASS_VALUE, 7, data at PASS_ADDR that signals success
TIMEOUT, 1000, cycles in RUN before TIMEOUT state
LOG_DEPTH, 8, store-log FIFO entries (power of 2)

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high
Address  in  BusWidth  byte address from core
Write_Data  in  BusWidth  store data from core
Mem_Write  in  1  store strobe, sampled at rising edge
Read_Data  out  BusWidth  combinational read data
Bus_Error  out  1  sticky; misaligned or out-of-range access
Status  out  2  0=IDLE 1=RUN 2=PASS 3=FAIL; TIMEOUT is reported as FAIL with Timed_Out=1
Timed_Out  out  1  sticky watchdog flag
Log_Valid  out  1  FIFO non-empty
Log_Addr  out  BusWidth  head entry address
Log_Data  out  BusWidth  head entry data
Log_Pop  in  1  consume head when Log_Valid=1
Log_Overflow  out  1  sticky; a store was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock CLK. RESET is synchronous, active-high.
- Reset values: Status=IDLE, Bus_Error=0, Timed_Out=0, Log_Valid=0, Log_Overflow=0, FIFO pointers and count=0, watchdog=0. RAM contents are not cleared.
- Read path:
  - Read_Data = RAM[Address[log2(DEPTH)+1:2]], combinational, zero latency.
  - If the address is out of range or misaligned, Read_Data=0 and Bus_Error sets, but only when Mem_Write=0 and Status=RUN. Unused address reads are not flagged outside RUN.
- Write path:
  - A store is accepted when Mem_Write=1, Address[1:0]=0 and Address<4*DEPTH.
  - RAM is updated at that edge. A load from the same address in the next cycle returns the new data.
  - A store failing the alignment or range check is ignored and sets Bus_Error. The checker still evaluates it.
- FSM:
  - IDLE→RUN on the first cycle after RESET deasserts.
  - RUN→PASS on a store with Address==PASS_ADDR and Write_Data==PASS_VALUE.
  - RUN→FAIL on any other store to PASS_ADDR.
  - RUN→FAIL with Timed_Out=1 when the watchdog reaches TIMEOUT-1 without a PASS_ADDR store.
  - PASS and FAIL are absorbing until RESET. Later stores still update RAM and the log.
  - The watchdog counts only in RUN. It increments every cycle and saturates when the state leaves RUN.
- Store-log FIFO:
  - Every accepted store pushes {Address, Write_Data} in the same edge.
  - Head outputs are registered: an entry is visible on Log_Valid/Log_Addr/Log_Data one cycle after its store.
  - Log_Pop when Log_Valid=0 is ignored.
  - Push with pop while full: both occur, count unchanged, no overflow.
  - Push without pop while full: entry dropped, Log_Overflow sets.
  - Pointers wrap modulo LOG_DEPTH.
- Simultaneous events: a store to PASS_ADDR in the same cycle the watchdog expires resolves to PASS/FAIL by data; Timed_Out stays 0.
- Reset mid-operation: FSM, flags, FIFO and watchdog return to reset values at that edge. Any store presented in that cycle is still written to RAM but is not logged or checked.

Test Plan:
- Reset at cycle 0, release at 3; store 0xA5 to addr 8, then load addr 8 → Read_Data=0xA5 next cycle; Status=RUN; Log_Valid=1 with Log_Addr=8, Log_Data=0xA5.
- Store 7 to addr 100 → Status=PASS next edge; a following store of 3 to addr 100 leaves Status=PASS, RAM[25]=3.
- Store 5 to addr 100 → Status=FAIL, Timed_Out=0; separately, no stores for TIMEOUT=20 cycles → Status=FAIL, Timed_Out=1 at cycle 20 after entering RUN.
- Stores to addr 6 (misaligned) and addr 256 with DEPTH=64 → Bus_Error=1, RAM unchanged, FIFO count unchanged.
- 9 stores with LOG_DEPTH=8 and no pops → Log_Overflow=1, 8 entries drained in order with addresses 0,4,…,28. Repeat with the FIFO full and store+pop in the same cycle → Log_Overflow stays 0.
- Assert RESET mid-run after 3 logged stores → Status=IDLE, Log_Valid=0, flags 0; RAM data written before reset still reads back.
